// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake skid buffer.
package hs_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } hs_state_e;

  localparam int unsigned HS_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/hs_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module hs_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hs_skid_buffer.sv
// Two-entry valid/ready register slice with registered s_ready, transfer/stall
// statistics and a sticky flag for upstream valid/data stability violations.
module hs_skid_buffer
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = HS_CNT_W_DEFAULT
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [CNT_W-1:0]  stall_count,
  output logic              proto_err
);

  hs_state_e         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              s_ready_q, s_ready_d;
  logic              proto_err_q, proto_err_d;
  logic              sv_prev_q;
  logic              sr_prev_q;
  logic [DATA_W-1:0] sd_prev_q;

  logic s_fire_s;
  logic m_fire_s;
  logic stall_s;
  logic proto_viol_s;

  assign m_valid  = (state_q != EMPTY);
  assign s_fire_s = s_valid && s_ready_q;
  assign m_fire_s = m_valid && m_ready;
  assign stall_s  = m_valid && !m_ready;

  // Occupancy FSM and data steering; main_q only moves on a load into EMPTY or on m_fire.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (s_fire_s) begin
          main_d  = s_data;
          state_d = BUSY;
        end else begin
          state_d = EMPTY;
        end
      end
      BUSY: begin
        if (s_fire_s && m_fire_s) begin
          main_d  = s_data;
          state_d = BUSY;
        end else if (s_fire_s) begin
          skid_d  = s_data;
          state_d = FULL;
        end else if (m_fire_s) begin
          state_d = EMPTY;
        end else begin
          state_d = BUSY;
        end
      end
      FULL: begin
        if (m_fire_s) begin
          main_d  = skid_q;
          state_d = BUSY;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  assign s_ready_d = (state_d != FULL);

  // A stalled upstream beat must keep s_valid high with unchanged data.
  assign proto_viol_s = sv_prev_q && !sr_prev_q && (!s_valid || (s_data != sd_prev_q));

  // Sticky violation flag; a new violation beats a simultaneous clear.
  always_comb begin
    proto_err_d = proto_err_q;
    if (proto_viol_s) begin
      proto_err_d = 1'b1;
    end else if (clr_stats) begin
      proto_err_d = 1'b0;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // Datapath, handshake and monitor registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= EMPTY;
      main_q      <= {DATA_W{1'b0}};
      skid_q      <= {DATA_W{1'b0}};
      s_ready_q   <= 1'b0;
      proto_err_q <= 1'b0;
      sv_prev_q   <= 1'b0;
      sr_prev_q   <= 1'b0;
      sd_prev_q   <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      s_ready_q   <= s_ready_d;
      proto_err_q <= proto_err_d;
      sv_prev_q   <= s_valid;
      sr_prev_q   <= s_ready_q;
      sd_prev_q   <= s_data;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_data    = main_q;
  assign proto_err = proto_err_q;

  hs_sat_counter #(.W(CNT_W)) u_xfer_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr_stats),
    .inc    (m_fire_s),
    .count  (xfer_count)
  );

  hs_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clr_stats),
    .inc    (stall_s),
    .count  (stall_count)
  );

endmodule

// File: tb/tb_hs_skid_buffer.sv
// Directed self-checking bench for hs_skid_buffer (4-bit counters to reach saturation quickly).
module tb_hs_skid_buffer;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          clr_stats;
  logic [CW-1:0] xfer_count;
  logic [CW-1:0] stall_count;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  hs_skid_buffer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .clr_stats   (clr_stats),
    .xfer_count  (xfer_count),
    .stall_count (stall_count),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b0; s_data = 32'h0; m_ready = 1'b0; clr_stats = 1'b0;
    #3;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_hs: m_valid=%b s_ready=%b m_data=%h, want 0 0 0", m_valid, s_ready, m_data);
    end
    checks++;
    if (xfer_count !== 4'd0 || stall_count !== 4'd0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_stats: xfer=%0d stall=%0d perr=%b, want 0 0 0", xfer_count, stall_count, proto_err);
    end
    tick();
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: s_ready=%b want 0", s_ready);
    end
    tick();
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL ready_first_edge: s_ready=%b m_valid=%b, want 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_stream();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(i);
      tick();
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'(i) || s_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_beat%0d: m_valid=%b m_data=%h s_ready=%b, want 1 %h 1", i, m_valid, m_data, s_ready, 32'(i));
      end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b0 || xfer_count !== 4'd8 || stall_count !== 4'd0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: m_valid=%b xfer=%0d stall=%0d perr=%b, want 0 8 0 0", m_valid, xfer_count, stall_count, proto_err);
    end
  endtask

  task automatic test_backpressure();
    clear_stats();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'hA || s_ready !== 1'b1 || stall_count !== 4'd0) begin
      errors++;
      $display("FAIL bp_first: m_valid=%b m_data=%h s_ready=%b stall=%0d, want 1 a 1 0", m_valid, m_data, s_ready, stall_count);
    end
    s_data = 32'hB;
    tick();
    checks++;
    if (s_ready !== 1'b0 || m_data !== 32'hA || stall_count !== 4'd1) begin
      errors++;
      $display("FAIL bp_full: s_ready=%b m_data=%h stall=%0d, want 0 a 1", s_ready, m_data, stall_count);
    end
    s_data = 32'hC;
    tick();
    tick();
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'hA || stall_count !== 4'd3) begin
      errors++;
      $display("FAIL bp_hold: s_ready=%b m_valid=%b m_data=%h stall=%0d, want 0 1 a 3", s_ready, m_valid, m_data, stall_count);
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_data !== 32'hB || m_valid !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: m_data=%h m_valid=%b s_ready=%b, want b 1 1", m_data, m_valid, s_ready);
    end
    tick();
    checks++;
    if (m_data !== 32'hC || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_third: m_data=%h m_valid=%b, want c 1", m_data, m_valid);
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b0 || xfer_count !== 4'd3 || stall_count !== 4'd3 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: m_valid=%b xfer=%0d stall=%0d perr=%b, want 0 3 3 0", m_valid, xfer_count, stall_count, proto_err);
    end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 32'h55;
    tick();
    s_data = 32'h66;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h66 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_swap: m_valid=%b m_data=%h s_ready=%b, want 1 66 1", m_valid, m_data, s_ready);
    end
    s_valid = 1'b0; m_ready = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h66) begin
      errors++;
      $display("FAIL b2b_hold: m_valid=%b m_data=%h, want 1 66", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: m_valid=%b want 0", m_valid);
    end
  endtask

  task automatic test_proto_err();
    clear_stats();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h11;
    tick();
    s_data = 32'h22;
    tick();
    tick();
    checks++;
    if (proto_err !== 1'b0 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL perr_quiet: proto_err=%b s_ready=%b, want 0 0", proto_err, s_ready);
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_set: proto_err=%b want 1", proto_err);
    end
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky: proto_err=%b want 1", proto_err);
    end
    clear_stats();
    checks++;
    if (proto_err !== 1'b0 || xfer_count !== 4'd0 || stall_count !== 4'd0) begin
      errors++;
      $display("FAIL perr_clear: perr=%b xfer=%0d stall=%0d, want 0 0 0", proto_err, xfer_count, stall_count);
    end
    s_valid = 1'b1; s_data = 32'h33;
    tick();
    s_valid = 1'b0; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || stall_count !== 4'd0) begin
      errors++;
      $display("FAIL perr_set_beats_clr: perr=%b stall=%0d, want 1 0", proto_err, stall_count);
    end
    m_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (m_valid !== 1'b0 || xfer_count !== 4'd2) begin
      errors++;
      $display("FAIL perr_drain: m_valid=%b xfer=%0d, want 0 2", m_valid, xfer_count);
    end
  endtask

  task automatic test_saturation();
    clear_stats();
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_data  = 32'(32'h100 + i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (xfer_count !== 4'd15 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_xfer: xfer=%0d m_valid=%b, want 15 0", xfer_count, m_valid);
    end
    s_valid = 1'b1; s_data = 32'h200;
    tick();
    s_valid = 1'b0; clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (xfer_count !== 4'd0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL sat_clr_wins: xfer=%0d m_valid=%b, want 0 0", xfer_count, m_valid);
    end
  endtask

  task automatic test_mid_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA;
    tick();
    s_data = 32'hB;
    tick();
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL mr_full: s_ready=%b m_valid=%b, want 0 1", s_ready, m_valid);
    end
    #2;
    resetn = 1'b0; s_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || m_data !== 32'h0 || stall_count !== 4'd0) begin
      errors++;
      $display("FAIL mr_async: m_valid=%b s_ready=%b m_data=%h stall=%0d, want 0 0 0 0", m_valid, s_ready, m_data, stall_count);
    end
    tick();
    resetn = 1'b1;
    m_ready = 1'b1;
    tick();
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL mr_idle: m_valid=%b s_ready=%b, want 0 1", m_valid, s_ready);
    end
    s_valid = 1'b1; s_data = 32'h77;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 32'h77) begin
      errors++;
      $display("FAIL mr_fresh: m_valid=%b m_data=%h, want 1 77", m_valid, m_data);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0 || xfer_count !== 4'd1) begin
      errors++;
      $display("FAIL mr_drain: m_valid=%b xfer=%0d, want 0 1", m_valid, xfer_count);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_proto_err();
    test_saturation();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
